// File: rtl/burst_ram_pkg.sv
// rtl/burst_ram_pkg.sv - shared burst constants, command encodings and controller state enum
package burst_ram_pkg;

   localparam int   BURST_COUNT = 4;
   localparam int   BEAT_W      = 2;
   localparam logic CMD_READ    = 1'b0;
   localparam logic CMD_WRITE   = 1'b1;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      READ_WAIT,
      READ_BURST,
      WRITE_BURST
   } state_t;

   function automatic logic is_last_beat(input logic [BEAT_W-1:0] beat);
      return beat == BEAT_W'(BURST_COUNT - 1);
   endfunction

endpackage

// File: rtl/burst_ram_if.sv
// rtl/burst_ram_if.sv - command, write-beat and read-beat signals of the burst memory
interface burst_ram_if #(
   parameter int ADDR_BITWIDTH = 21
);
   logic                     init_calib;
   logic                     cmd;
   logic                     cmd_en;
   logic [ADDR_BITWIDTH-1:0] addr;
   logic [63:0]              wr_data;
   logic [7:0]               data_mask;
   logic [63:0]              rd_data;
   logic                     rd_data_valid;

   modport master (
      input  init_calib, rd_data, rd_data_valid,
      output cmd, cmd_en, addr, wr_data, data_mask
   );

   modport slave (
      output init_calib, rd_data, rd_data_valid,
      input  cmd, cmd_en, addr, wr_data, data_mask
   );
endinterface

// File: rtl/burst_ram_array.sv
// rtl/burst_ram_array.sv - single-port 64-bit word array with per-byte write enables and registered read
module burst_ram_array #(
   parameter int DEPTH_BITWIDTH = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rd_en,
   input  logic [7:0]                we,
   input  logic [DEPTH_BITWIDTH-1:0] addr,
   input  logic [63:0]               wdata,
   output logic [63:0]               q
);
   localparam int WORDS = 1 << DEPTH_BITWIDTH;

   logic [63:0] mem [WORDS];

   // Storage has no reset so contents survive rst_n.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (we[i]) begin
            mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (rd_en) begin
         q <= mem[addr];
      end
   end

endmodule

// File: rtl/burst_ram.sv
// rtl/burst_ram.sv - 4-beat burst memory controller with init delay and fixed read latency
module burst_ram
   import burst_ram_pkg::*;
#(
   parameter int DEPTH_BITWIDTH = 10,
   parameter int INIT_CYCLES    = 16,
   parameter int READ_LATENCY   = 4,
   parameter int ADDR_BITWIDTH  = 21
) (
   input  logic       clk,
   input  logic       rst_n,
   burst_ram_if.slave bus
);
   localparam int INIT_W = $clog2(INIT_CYCLES + 2);
   localparam int WAIT_W = $clog2(READ_LATENCY + 2);

   state_t                    state, state_nxt;
   logic [INIT_W-1:0]         init_cnt, init_cnt_nxt;
   logic [WAIT_W-1:0]         wait_cnt, wait_cnt_nxt;
   logic [BEAT_W-1:0]         beat, beat_nxt;
   logic [DEPTH_BITWIDTH-1:0] ptr, ptr_nxt, mem_addr;
   logic                      mem_rd;
   logic [7:0]                mem_we;
   logic [63:0]               mem_q;
   logic                      valid;
   logic                      unused_addr;

   assign unused_addr = ^bus.addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         init_cnt <= '0;
         wait_cnt <= '0;
         beat     <= '0;
         ptr      <= '0;
         valid    <= 1'b0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
         wait_cnt <= wait_cnt_nxt;
         beat     <= beat_nxt;
         ptr      <= ptr_nxt;
         valid    <= (state_nxt == READ_BURST);
      end
   end

   // The array read is issued one cycle ahead of each valid beat because its output is registered.
   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      wait_cnt_nxt = wait_cnt;
      beat_nxt     = beat;
      ptr_nxt      = ptr;
      mem_addr     = ptr;
      mem_rd       = 1'b0;
      mem_we       = 8'h00;
      case (state)
         INIT: begin
            if (int'(init_cnt) >= INIT_CYCLES - 1) begin
               state_nxt = IDLE;
            end else begin
               init_cnt_nxt = init_cnt + INIT_W'(1);
            end
         end
         IDLE: begin
            mem_addr     = bus.addr[DEPTH_BITWIDTH-1:0];
            beat_nxt     = '0;
            wait_cnt_nxt = '0;
            if (bus.cmd_en) begin
               if (bus.cmd == CMD_WRITE) begin
                  mem_we    = ~bus.data_mask;
                  ptr_nxt   = bus.addr[DEPTH_BITWIDTH-1:0] + DEPTH_BITWIDTH'(1);
                  beat_nxt  = BEAT_W'(1);
                  state_nxt = WRITE_BURST;
               end else begin
                  ptr_nxt   = bus.addr[DEPTH_BITWIDTH-1:0];
                  state_nxt = READ_WAIT;
               end
            end
         end
         READ_WAIT: begin
            if (int'(wait_cnt) >= READ_LATENCY - 1) begin
               mem_rd    = 1'b1;
               ptr_nxt   = ptr + DEPTH_BITWIDTH'(1);
               beat_nxt  = '0;
               state_nxt = READ_BURST;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         READ_BURST: begin
            if (is_last_beat(beat)) begin
               beat_nxt  = '0;
               state_nxt = IDLE;
            end else begin
               mem_rd   = 1'b1;
               ptr_nxt  = ptr + DEPTH_BITWIDTH'(1);
               beat_nxt = beat + BEAT_W'(1);
            end
         end
         WRITE_BURST: begin
            mem_we  = ~bus.data_mask;
            ptr_nxt = ptr + DEPTH_BITWIDTH'(1);
            if (is_last_beat(beat)) begin
               beat_nxt  = '0;
               state_nxt = IDLE;
            end else begin
               beat_nxt = beat + BEAT_W'(1);
            end
         end
         default: begin
            state_nxt = INIT;
         end
      endcase
   end

   burst_ram_array #(
      .DEPTH_BITWIDTH(DEPTH_BITWIDTH)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .rd_en (mem_rd),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (bus.wr_data),
      .q     (mem_q)
   );

   assign bus.init_calib    = (state != INIT);
   assign bus.rd_data       = mem_q;
   assign bus.rd_data_valid = valid;

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 SHALL have parameter DEPTH_BITWIDTH, default 10, meaning log2 of memory depth in 64-bit words.
REQ-002 SHALL have parameter INIT_CYCLES, default 16, meaning cycles after reset release before init_calib rises.
REQ-003 SHALL have parameter READ_LATENCY, default 4, meaning cycles from accepted read cmd_en to first rd_data_valid (minimum 1).
REQ-004 SHALL have parameter ADDR_BITWIDTH, default 21, meaning addr port width.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk input 1 (all logic on rising edge); rst_n input 1 (async assert, active low).
REQ-006 SHALL have port init_calib, output 1, high when ready for commands.
REQ-007 SHALL have port cmd, input 1, 0 read, 1 write.
REQ-008 SHALL have port cmd_en, input 1, cmd and addr valid this cycle.
REQ-009 SHALL have port addr, input ADDR_BITWIDTH, 64-bit word address of first beat.
REQ-010 SHALL have port wr_data, input 64, write beat data.
REQ-011 SHALL have port data_mask, input 8, bit i=1 means byte i of the beat is not written.
REQ-012 SHALL have port rd_data, output 64, read beat data.
REQ-013 SHALL have port rd_data_valid, output 1, rd_data valid this cycle.

Function
REQ-014 SHALL implement states INIT, IDLE, READ_WAIT, READ_BURST, WRITE_BURST.
REQ-015 INIT: count INIT_CYCLES clocks, then enter IDLE; init_calib SHALL be 1 exactly in non-INIT states.
REQ-016 IDLE: cmd_en=1 is accepted; other states SHALL ignore cmd_en, with no side effect.
REQ-017 Burst length SHALL be 4 beats; beat n address = (addr + n) mod 2^DEPTH_BITWIDTH; addr bits above DEPTH_BITWIDTH ignored.
REQ-018 Write: beat 0 = wr_data/data_mask in the accept cycle; beats 1..3 sampled on the next 3 consecutive cycles in WRITE_BURST; then IDLE.
REQ-019 Write: each unmasked byte SHALL be stored at the clock edge of its beat; fully masked beat writes nothing.
REQ-020 Read: after the accept cycle, go to READ_WAIT; first rd_data_valid SHALL occur exactly READ_LATENCY cycles after the accept edge.
REQ-021 Read: 4 consecutive valid beats in READ_BURST, beat n = word at beat-n address; then IDLE.
REQ-022 rd_data_valid SHALL be 0 in all other cycles; rd_data is don't-care when not valid but SHALL be registered.
REQ-023 Earliest next accept SHALL be the cycle after the last write beat or the cycle after the last read beat.
REQ-024 cmd_en during the last beat cycle SHALL be ignored.
REQ-025 Read of a word written by an earlier completed burst SHALL return the new data; wrap from max word to word 0 is legal.

Reset
REQ-026 rst_n low SHALL force state INIT, init counter 0, init_calib 0, rd_data_valid 0, rd_data 0, beat counter 0.
REQ-027 Reset mid-burst SHALL abort the burst: beats already written remain, no further beats written, no valid asserted.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-029 Package burst_ram_pkg SHALL hold BURST_COUNT=4, CMD_READ=0, CMD_WRITE=1 and the state enum; RAMIO-side code imports the same constants.
REQ-030 The byte-masked single-port 64-bit array SHALL be sub-module burst_ram_array (write enable per byte, registered read).

Verification
REQ-031 Init: release rst_n -> init_calib 0 for 16 cycles, 1 on cycle 17; cmd_en during INIT -> ignored, no valid.
REQ-032 Write then read: write addr 0x10 beats 0x1111..,0x2222..,0x3333..,0x4444.., mask 0 -> read 0x10 returns same 4 beats, first valid 4 cycles after accept.
REQ-033 Mask: write addr 0x20 with 0xFFFF_FFFF_FFFF_FFFF, then 0x0 with mask 0x0F -> read beat 0 = 0x0000_0000_FFFF_FFFF.
REQ-034 Wrap: write addr 0x3FE, 4 beats -> words 0x3FE,0x3FF,0x000,0x001 updated; read 0x3FE returns them in order.
REQ-035 Busy ignore: cmd_en held high throughout a read burst -> only one burst of 4 valids; new accept the cycle after beat 3.
REQ-036 Reset mid-write after beat 1 -> words addr, addr+1 hold new data, addr+2, addr+3 unchanged; init_calib re-runs 16 cycles.
